// File: rtl/mmio_bridge.sv
// mmio_bridge: memory-stage load/store bridge. Serves an internal output
// register in zero wait states and forwards other mapped accesses to one of
// NSLOT external bus slots, stalling the pipeline until the slot acks or the
// access times out.
module mmio_bridge #(
    parameter int          NSLOT   = 4,
    parameter logic [15:0] BASE_HI = 16'h1001,
    parameter logic [15:0] GPIO_HI = 16'h0008,
    parameter int          GPIO_W  = 8,
    parameter int          TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           req_len,
    input  logic                 req_sext,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 stall,
    output logic [31:0]          rdata,
    output logic                 rdata_valid,
    output logic                 err,
    output logic [NSLOT-1:0]     bus_sel,
    output logic                 bus_we,
    output logic [3:0]           bus_be,
    output logic [15:0]          bus_addr,
    output logic [31:0]          bus_wdata,
    input  logic [NSLOT*32-1:0]  bus_rdata,
    input  logic [NSLOT-1:0]     bus_ack,
    output logic [GPIO_W-1:0]    gpio_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LEN_B = 3'b001;
    localparam logic [2:0] LEN_H = 3'b010;
    localparam logic [2:0] LEN_W = 3'b100;
    // Last BUSY cycle index; BUSY lasts at most TIMEOUT cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t              state_reg, state_next;
    logic [NSLOT-1:0]    sel_reg, sel_next;
    logic                we_reg, we_next;
    logic [3:0]          be_reg, be_next;
    logic [15:0]         addr_reg, addr_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic [2:0]          len_reg, len_next;
    logic                sext_reg, sext_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic [31:0]         rdata_reg, rdata_next;
    logic                err_reg, err_next;
    logic [GPIO_W-1:0]   gpio_reg, gpio_next;

    logic [NSLOT-1:0]    slot_hit;
    logic [31:0]         slot_word [NSLOT];
    logic [31:0]         sel_word;
    logic                ack_hit;
    logic [31:0]         gpio_ext;
    logic                is_gpio;
    logic                len_ok;
    logic                misaligned;
    logic                bad_req;

    // Byte enables for the addressed lane(s).
    function automatic logic [3:0] lane_be(input logic [2:0] len, input logic [1:0] a);
        logic [3:0] be;
        case (len)
            LEN_B:   be = 4'b0001 << a;
            LEN_H:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated onto every lane so a slot can pick any lane.
    function automatic logic [31:0] lane_wdata(input logic [2:0] len, input logic [31:0] d);
        logic [31:0] w;
        case (len)
            LEN_B:   w = {4{d[7:0]}};
            LEN_H:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Shift the addressed lane down to bit 0 and zero/sign extend it.
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] len,
                                             input logic [1:0] a, input logic sext);
        logic [31:0] r;
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (len)
            LEN_B:   r = sext ? {{24{b[7]}}, b} : {24'h0, b};
            LEN_H:   r = sext ? {{16{h[15]}}, h} : {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Per-slot address decode and read-word masking by the latched select.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            localparam logic [15:0] SLOT_HI = BASE_HI + 16'(gi);
            assign slot_hit[gi]  = (req_addr[31:16] == SLOT_HI);
            assign slot_word[gi] = sel_reg[gi] ? bus_rdata[32*gi +: 32] : 32'h0;
        end
    endgenerate

    // OR-combine masked slot words; at most one is non-zero.
    always_comb begin
        sel_word = 32'h0;
        for (int i = 0; i < NSLOT; i++) begin
            sel_word = sel_word | slot_word[i];
        end
    end

    assign ack_hit = |(bus_ack & sel_reg);

    // Zero-extended view of the output register for loads.
    always_comb begin
        gpio_ext = 32'h0;
        gpio_ext[GPIO_W-1:0] = gpio_reg;
    end

    // Request classification.
    always_comb begin
        is_gpio    = (req_addr[31:16] == GPIO_HI);
        len_ok     = (req_len == LEN_B) || (req_len == LEN_H) || (req_len == LEN_W);
        misaligned = ((req_len == LEN_H) && req_addr[0]) ||
                     ((req_len == LEN_W) && (req_addr[1:0] != 2'b00));
        bad_req    = !len_ok || misaligned || (!is_gpio && !(|slot_hit));
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            we_reg    <= 1'b0;
            be_reg    <= 4'h0;
            addr_reg  <= 16'h0;
            wdata_reg <= 32'h0;
            len_reg   <= 3'h0;
            sext_reg  <= 1'b0;
            cnt_reg   <= 8'h0;
            rdata_reg <= 32'h0;
            err_reg   <= 1'b0;
            gpio_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            we_reg    <= we_next;
            be_reg    <= be_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            len_reg   <= len_next;
            sext_reg  <= sext_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            gpio_reg  <= gpio_next;
        end
    end

    // Next-state and pipeline-facing outputs; everything is quiet during reset.
    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        we_next     = we_reg;
        be_next     = be_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        len_next    = len_reg;
        sext_next   = sext_reg;
        cnt_next    = cnt_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        gpio_next   = gpio_reg;
        stall       = 1'b0;
        rdata       = 32'h0;
        rdata_valid = 1'b0;
        err         = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        if (bad_req) begin
                            err         = 1'b1;
                            rdata_valid = 1'b1;
                        end else if (is_gpio) begin
                            rdata_valid = 1'b1;
                            if (req_we) begin
                                gpio_next = req_wdata[GPIO_W-1:0];
                            end else begin
                                rdata = gpio_ext;
                            end
                        end else begin
                            stall      = 1'b1;
                            sel_next   = slot_hit;
                            we_next    = req_we;
                            be_next    = lane_be(req_len, req_addr[1:0]);
                            addr_next  = req_addr[15:0];
                            wdata_next = lane_wdata(req_len, req_wdata);
                            len_next   = req_len;
                            sext_next  = req_sext;
                            cnt_next   = 8'h0;
                            state_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    stall = 1'b1;
                    if (ack_hit) begin
                        rdata_next = we_reg ? 32'h0
                                            : fmt_load(sel_word, len_reg, addr_reg[1:0], sext_reg);
                        err_next   = 1'b0;
                        state_next = DONE;
                    end else if (cnt_reg == TO_LAST) begin
                        rdata_next = 32'h0;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 8'h1;
                    end
                end
                DONE: begin
                    rdata_valid = 1'b1;
                    rdata       = rdata_reg;
                    err         = err_reg;
                    state_next  = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus_sel   = (state_reg == BUSY) ? sel_reg : '0;
    assign bus_we    = (state_reg == BUSY) ? we_reg  : 1'b0;
    assign bus_be    = (state_reg == BUSY) ? be_reg  : 4'h0;
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign gpio_out  = gpio_reg;

endmodule
